// File: rtl/sign_win_pkg.sv
// Shared types and helpers for the sign_window_rows row-window generator.
package sign_win_pkg;

  localparam logic [1:0] SGN_ZERO = 2'b00;
  localparam logic [1:0] SGN_POS  = 2'b01;
  localparam logic [1:0] SGN_NEG  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  // First row index whose column is emitted downstream.
  function automatic int emit_row(input int len, input int pad);
    return (pad != 0) ? (len - 1) / 2 : len - 1;
  endfunction

  // Number of internally generated bottom-padding rows.
  function automatic int flush_rows(input int len, input int pad);
    return (pad != 0) ? (len - 1) / 2 : 0;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM: synchronous read-first read port, one write port.
module line_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // NOTE: storage arrays get no reset so they map onto block RAM; stale words are masked upstream.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sign_window_rows.sv
// Sign-code row-window generator: buffers LEN-1 previous rows and emits LEN-row columns.
module sign_window_rows
  import sign_win_pkg::*;
#(
  parameter int WIDTH_D = 27,
  parameter int SIZE    = 28,
  parameter int CHANNEL = 128,
  parameter int LEN     = 3,
  parameter int PAD     = 1
) (
  input  logic               i_sclk,
  input  logic               i_rst_n,
  input  logic               i_vsync,
  input  logic               i_hsync,
  input  logic               i_valid,
  input  logic [WIDTH_D-1:0] i_tdata,
  output logic               o_vsync,
  output logic               o_hsync,
  output logic               o_valid,
  output logic [2*LEN-1:0]   o_tdata,
  output logic               o_eof,
  output logic               o_err
);

  localparam int DEPTH = SIZE * CHANNEL;
  localparam int COL_W = $clog2(DEPTH);
  localparam int ROW_W = $clog2(SIZE + LEN + 2) + 1;
  localparam int RAM_W = 2 * (LEN - 1);
  localparam int E     = emit_row(LEN, PAD);
  localparam int F     = flush_rows(LEN, PAD);
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(DEPTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST_IN  = ROW_W'(SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST_OUT = ROW_W'(SIZE - 1 + F);
  localparam logic [ROW_W-1:0] ROW_EMIT     = ROW_W'(E);

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d, col_eff;
  logic [ROW_W-1:0]   row_q, row_d, row_eff;
  logic               err_q, err_d;
  logic               beat_go;
  logic [1:0]         code_in;

  logic               s1_valid_q;
  logic [1:0]         s1_code_q;
  logic [COL_W-1:0]   s1_col_q;
  logic [ROW_W-1:0]   s1_row_q;
  logic [RAM_W-1:0]   rd_data, wr_data;
  logic [2*LEN-1:0]   win_masked;
  logic               emit, eof_beat;

  logic               out_valid_q, out_hsync_q, out_eof_q;
  logic [2*LEN-1:0]   out_tdata_q;
  logic [1:0]         vs_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    col_eff = col_q;
    row_eff = row_q;
    beat_go = 1'b0;
    code_in = SGN_ZERO;
    if (i_vsync) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          // A row start in mid-row realigns to column 0 of the next row.
          if (i_hsync && col_q != '0) begin
            err_d   = 1'b1;
            col_eff = '0;
            row_eff = row_q + 1'b1;
          end
          col_d = col_eff;
          row_d = row_eff;
          if (i_valid) begin
            beat_go = 1'b1;
            state_d = RUN;
            if (i_tdata == '0)             code_in = SGN_ZERO;
            else if (i_tdata[WIDTH_D-1])   code_in = SGN_NEG;
            else                           code_in = SGN_POS;
            if (col_eff == COL_LAST) begin
              col_d = '0;
              row_d = row_eff + 1'b1;
              if (row_eff == ROW_LAST_IN) state_d = (F > 0) ? FLUSH : DONE;
            end else begin
              col_d = col_eff + 1'b1;
            end
          end
        end
        FLUSH: begin
          beat_go = 1'b1;
          err_d   = err_q | i_valid;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_LAST_OUT) state_d = DONE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        DONE:    err_d = err_q | i_valid;
        default: state_d = IDLE;
      endcase
    end
  end

  line_ram #(.DEPTH(DEPTH), .WIDTH(RAM_W)) u_line_ram (
    .clk_i   (i_sclk),
    .we_i    (s1_valid_q),
    .waddr_i (s1_col_q),
    .wdata_i (wr_data),
    .re_i    (beat_go),
    .raddr_i (col_eff),
    .rdata_o (rd_data)
  );

  // Shift the column history by one row: oldest slot drops out, new code enters slot 1.
  if (LEN == 2) begin : g_wr_short
    assign wr_data = s1_code_q;
  end else begin : g_wr_shift
    assign wr_data = {rd_data[RAM_W-3:0], s1_code_q};
  end

  always_comb begin
    win_masked = {rd_data, s1_code_q};
    for (int k = 1; k < LEN; k++) begin
      if (s1_row_q < ROW_W'(k)) win_masked[2*k +: 2] = SGN_ZERO;
    end
  end

  assign emit     = s1_valid_q && (s1_row_q >= ROW_EMIT);
  assign eof_beat = emit && (s1_row_q == ROW_LAST_OUT) && (s1_col_q == COL_LAST);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_code_q   <= SGN_ZERO;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      out_valid_q <= 1'b0;
      out_hsync_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_tdata_q <= '0;
      vs_q        <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      err_q       <= err_d;
      s1_valid_q  <= beat_go;
      if (beat_go) begin
        s1_code_q <= code_in;
        s1_col_q  <= col_eff;
        s1_row_q  <= row_eff;
      end
      out_valid_q <= emit;
      out_hsync_q <= emit && (s1_col_q == '0);
      out_eof_q   <= eof_beat;
      if (emit) out_tdata_q <= win_masked;
      vs_q        <= {vs_q[0], i_vsync};
    end
  end

  assign o_vsync = vs_q[1];
  assign o_hsync = out_hsync_q;
  assign o_valid = out_valid_q;
  assign o_tdata = out_tdata_q;
  assign o_eof   = out_eof_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_sign_window_rows.sv
// Randomised bench: three configurations share one input stream, each checked against a row-level model.
module tb_sign_window_rows;

  localparam int WD     = 8;
  localparam int SZ     = 4;
  localparam int CH     = 2;
  localparam int ROWLEN = SZ * CH;
  localparam int TOTAL  = SZ * ROWLEN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0, hsync = 1'b0, valid = 1'b0;
  logic [WD-1:0] tdata = '0;

  logic       ovs0, ohs0, ov0, oeof0, oerr0;
  logic [5:0] od0;
  logic       ovs1, ohs1, ov1, oeof1, oerr1;
  logic [5:0] od1;
  logic       ovs2, ohs2, ov2, oeof2, oerr2;
  logic [9:0] od2;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sign_window_rows #(.WIDTH_D(WD), .SIZE(SZ), .CHANNEL(CH), .LEN(3), .PAD(1)) dut_p1l3 (
    .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_valid(valid),
    .i_tdata(tdata), .o_vsync(ovs0), .o_hsync(ohs0), .o_valid(ov0), .o_tdata(od0),
    .o_eof(oeof0), .o_err(oerr0));

  sign_window_rows #(.WIDTH_D(WD), .SIZE(SZ), .CHANNEL(CH), .LEN(3), .PAD(0)) dut_p0l3 (
    .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_valid(valid),
    .i_tdata(tdata), .o_vsync(ovs1), .o_hsync(ohs1), .o_valid(ov1), .o_tdata(od1),
    .o_eof(oeof1), .o_err(oerr1));

  sign_window_rows #(.WIDTH_D(WD), .SIZE(SZ), .CHANNEL(CH), .LEN(5), .PAD(1)) dut_p1l5 (
    .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_valid(valid),
    .i_tdata(tdata), .o_vsync(ovs2), .o_hsync(ohs2), .o_valid(ov2), .o_tdata(od2),
    .o_eof(oeof2), .o_err(oerr2));

  typedef struct {
    int          cyc;
    logic [63:0] data;
    bit          hs;
    bit          eof;
  } beat_t;

  beat_t         act0[$], act1[$], act2[$];
  int            ovs_cyc = -1;
  logic [WD-1:0] data_a[TOTAL];
  int            in_cyc[TOTAL];
  int            n_checks = 0;
  int            n_errors = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov0) act0.push_back('{cyc: cyc, data: 64'(od0), hs: ohs0, eof: oeof0});
      if (ov1) act1.push_back('{cyc: cyc, data: 64'(od1), hs: ohs1, eof: oeof1});
      if (ov2) act2.push_back('{cyc: cyc, data: 64'(od2), hs: ohs2, eof: oeof2});
      if (ovs0) ovs_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vsync = 1'b0;
    hsync = 1'b0;
    valid = 1'b0;
  endtask

  function automatic logic [1:0] sgn(input logic [WD-1:0] v);
    if ($signed(v) == 0) return 2'b00;
    if ($signed(v) > 0)  return 2'b01;
    return 2'b11;
  endfunction

  // Reference: which rows are emitted, what each window slot holds, and when it appears.
  task automatic build_exp(input int len, input int pad, output beat_t q[$]);
    int e, f;
    e = (pad != 0) ? (len - 1) / 2 : len - 1;
    f = (pad != 0) ? (len - 1) / 2 : 0;
    q = {};
    for (int r = e; r <= SZ - 1 + f; r++) begin
      for (int c = 0; c < ROWLEN; c++) begin
        beat_t b;
        b.data = '0;
        for (int k = 0; k < len; k++) begin
          if (r - k >= 0 && r - k < SZ) b.data[2*k +: 2] = sgn(data_a[(r - k) * ROWLEN + c]);
        end
        if (r < SZ) b.cyc = in_cyc[r * ROWLEN + c] + 2;
        else        b.cyc = in_cyc[TOTAL - 1] + 1 + (r - SZ) * ROWLEN + c + 2;
        b.hs  = (c == 0);
        b.eof = (r == SZ - 1 + f) && (c == ROWLEN - 1);
        q.push_back(b);
      end
    end
  endtask

  task automatic compare_dut(input string name, input beat_t act[$], input int len, input int pad);
    beat_t exp[$];
    build_exp(len, pad, exp);
    check({name, "_count"}, 64'(act.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < act.size()) begin
        check($sformatf("%s_cyc[%0d]", name, i), 64'(act[i].cyc), 64'(exp[i].cyc));
        check($sformatf("%s_data[%0d]", name, i), act[i].data, exp[i].data);
        check($sformatf("%s_hs_eof[%0d]", name, i), {62'd0, act[i].hs, act[i].eof},
              {62'd0, exp[i].hs, exp[i].eof});
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {61'd0, ov0, ov1, ov2}, 64'd0);
    check({tag, "_tdata"}, {42'd0, od0, od1, od2}, 64'd0);
    check({tag, "_hs_eof"}, {58'd0, ohs0, ohs1, ohs2, oeof0, oeof1, oeof2}, 64'd0);
    check({tag, "_err_vs"}, {58'd0, oerr0, oerr1, oerr2, ovs0, ovs1, ovs2}, 64'd0);
  endtask

  task automatic run_frame(input bit do_vs, input bit gaps, input bit new_data, input bit sign_vec);
    int vs_at;
    if (new_data) begin
      for (int b = 0; b < TOTAL; b++) data_a[b] = ($urandom_range(3) == 0) ? '0 : WD'($urandom);
    end
    if (sign_vec) begin
      data_a[16] = 8'd0;
      data_a[17] = 8'd5;
      data_a[18] = 8'hFF;
      data_a[19] = 8'h7F;
      data_a[20] = 8'h80;
    end
    vs_at = -1;
    if (do_vs) begin
      step(); idle_inputs(); vsync = 1'b1; vs_at = cyc;
      step(); vsync = 1'b0;
    end
    act0 = {}; act1 = {}; act2 = {};
    for (int b = 0; b < TOTAL; b++) begin
      if (gaps) begin
        int g = 0;
        while (g < 8 && $urandom_range(1) == 0) begin
          step(); idle_inputs(); g++;
        end
      end
      step();
      valid = 1'b1;
      hsync = (b % ROWLEN == 0);
      tdata = data_a[b];
      in_cyc[b] = cyc;
    end
    step(); idle_inputs();
    repeat (40) step();
    compare_dut("p1l3", act0, 3, 1);
    compare_dut("p0l3", act1, 3, 0);
    compare_dut("p1l5", act2, 5, 1);
    check("frame_err", {61'd0, oerr0, oerr1, oerr2}, 64'd0);
    if (do_vs) check("vsync_latency", 64'(ovs_cyc), 64'(vs_at + 2));
  endtask

  logic [1:0] sign_exp[5] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b11};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;

    // Gapless frame with the sign-mapping vector at the start of row 2.
    run_frame(1'b1, 1'b0, 1'b1, 1'b1);
    check("p1l3_total", 64'(act0.size()), 64'd32);
    check("p0l3_total", 64'(act1.size()), 64'd16);
    check("p1l5_total", 64'(act2.size()), 64'd32);
    for (int i = 0; i < 5; i++)
      check($sformatf("sign_map[%0d]", i), 64'(act0[8 + i].data[1:0]), 64'(sign_exp[i]));

    // A beat offered after the frame has completed is dropped and flagged.
    step(); valid = 1'b1; tdata = 8'd9;
    step(); idle_inputs();
    repeat (4) step();
    check("done_valid_err", {61'd0, oerr0, oerr1, oerr2}, 64'd7);
    check("done_valid_dropped", 64'(act0.size() + act1.size() + act2.size()), 64'd80);

    // Same data, random input gaps.
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);

    // Row start in mid-row at col 3.
    step(); idle_inputs(); vsync = 1'b1;
    step(); vsync = 1'b0;
    for (int b = 0; b < 3; b++) begin
      step(); valid = 1'b1; hsync = (b == 0); tdata = WD'($urandom);
    end
    step(); idle_inputs(); hsync = 1'b1;
    step(); idle_inputs();
    check("hsync_err_set", {61'd0, oerr0, oerr1, oerr2}, 64'd7);
    repeat (5) step();
    check("hsync_err_sticky", {61'd0, oerr0, oerr1, oerr2}, 64'd7);
    vsync = 1'b1;
    step(); vsync = 1'b0;
    check("vsync_clears_err", {61'd0, oerr0, oerr1, oerr2}, 64'd0);
    run_frame(1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of row 2, then a fresh frame with stale RAM.
    step(); idle_inputs(); vsync = 1'b1;
    step(); vsync = 1'b0;
    for (int b = 0; b < 20; b++) begin
      step(); valid = 1'b1; hsync = (b % ROWLEN == 0); tdata = WD'($urandom);
    end
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    idle_inputs();
    repeat (3) step();
    check_outputs_zero("reset_hold");
    @(negedge clk) rst_n = 1'b1;
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sign_window_rows.md
# sign_window_rows

Parametrised row-window generator for binarised feature maps. It converts each signed activation to a 2-bit sign code and buffers LEN-1 previous rows in one internal line RAM. Each beat it presents a vertical LEN-row column of sign codes to the binary convolution stage. It replaces fixed 3-row FIFO chains with a configurable-depth buffer that supports optional "same" zero padding, generates its own bottom-padding flush rows and flags stream errors.

## Interface
- WIDTH_D, 27, width of signed input activation
- SIZE, 28, feature-map height and width in pixels
- CHANNEL, 128, channels interleaved per pixel; one row = SIZE*CHANNEL beats (must be ≥ 2)
- LEN, 3, window height in rows, 2..7
- PAD, 1, 1 = "same" padding (LEN must be odd), 0 = valid-only windows
- i_sclk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_vsync  in  1  frame-start pulse; synchronously clears all frame state
- i_hsync  in  1  row-start pulse, coincident with or preceding a row's first beat
- i_valid  in  1  input beat strobe
- i_tdata  in  WIDTH_D  signed activation
- o_vsync  out  1  i_vsync delayed 2 cycles
- o_hsync  out  1  pulse on first output beat of each emitted row
- o_valid  out  1  output beat strobe
- o_tdata  out  2*LEN  window column; bits [1:0] = newest row, [2k+1:2k] = row delayed k rows
- o_eof  out  1  pulse on last output beat of the frame
- o_err  out  1  sticky stream error, cleared by i_vsync

## Operation
- Sign code: zero → 2'b00, positive → 2'b01, negative → 2'b11.
- Column counter col (0..SIZE*CHANNEL-1) counts accepted beats and wraps to 0, advancing row counter row. col is the line-RAM address.
- i_hsync while col ≠ 0 → o_err set, col forced to 0, row advanced.
- Line RAM word is 2*(LEN-1) bits and holds rows delayed 1..LEN-1. Each beat reads the word at col, then writes back {rd[2*(LEN-2)-1:0], new_code} to the same address.
- Slot k is masked to 2'b00 when row-k < 0, giving top padding.
- Emit rule: a beat is emitted when row ≥ E, where E = LEN-1 (PAD=0) or (LEN-1)/2 (PAD=1).
- Rows emitted per frame: SIZE-LEN+1 (PAD=0) or SIZE (PAD=1).
- State machine:
  - IDLE: after reset or i_vsync; on the first i_valid go to RUN.
  - RUN: on the last beat of row SIZE-1, go to DONE (PAD=0 or LEN=1) or FLUSH (PAD=1).
  - FLUSH: generates (LEN-1)/2 rows of internal beats, one per cycle, with new_code = 0; input is not accepted. Go to DONE after the last flush beat.
  - DONE: wait for i_vsync.
- i_valid in FLUSH or DONE → beat dropped, o_err set.
- i_vsync in any state → IDLE, col = row = 0, o_err cleared. RAM contents are not cleared; they are masked by the row < k rule.
- i_vsync has priority over a simultaneous i_valid; that beat is dropped.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Latency: i_valid at cycle t → o_valid/o_tdata at t+2. Stage 1 is the RAM read; stage 2 registers the output.
- FLUSH starts the cycle after the last input beat and emits continuously at one beat per cycle. The first flush output appears 2 cycles later.
- o_eof coincides with the last o_valid of the frame.
- Read-first RAM: the write at stage-1 address never collides with the stage-0 read because consecutive addresses differ (depth ≥ 2).
- Input gaps (i_valid low) are allowed; the pipeline holds and no output is produced.

## Structure
- Package sign_win_pkg holds:
  - the sign-code localparams (SGN_ZERO, SGN_POS, SGN_NEG);
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - a function returning E from LEN and PAD.
- Sub-module line_ram: simple dual-port, synchronous read, read-first; parameters DEPTH = SIZE*CHANNEL and WIDTH = 2*(LEN-1).
- Top level contains the counters, FSM, masking and output registers.

## Test plan
All scenarios use WIDTH_D=8, SIZE=4, CHANNEL=2, LEN=3 unless stated.
- Sign mapping: inputs 0, 5, -1, 127, -128 → new-row codes 00, 01, 11, 01, 11 at t+2.
- PAD=1 full frame of 32 beats:
  - 32 o_valid output beats, first at row 1 with slot 2 = 00;
  - last 8 outputs from FLUSH with bits [1:0] = 00;
  - o_eof on beat 32;
  - o_err = 0.
- PAD=0 same frame: 16 output beats, starting with the first beat of row 2; no FLUSH; o_eof on beat 16.
- i_hsync at col 3: o_err rises and stays high; the next i_vsync clears it and the following frame is error-free.
- Random i_valid gaps (50 % duty): output sequence identical to the gapless run, and every output beat appears 2 cycles after its input beat.
- i_rst_n low mid-row 2: all outputs 0 immediately. After release, a new frame behaves as from power-up, with stale RAM fully masked. Repeat with LEN=5, PAD=1 and check 2 flush rows.
